// File: rtl/downcounter_reload_if.sv
// Control/status bundle for downcounter_reload.
// master: drives load, load_val, en, auto_reload; samples count, tc, busy, done.
// slave : the counter itself.
interface downcounter_reload_if #(
    parameter int unsigned WIDTH = 3
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, en, auto_reload,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output count, tc, busy, done
    );
endinterface

// File: rtl/downcounter_reload.sv
// Loadable down counter with terminal-count pulse and optional auto-reload.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - downcounter_reload_if.slave:
//          load/load_val (start value), en (count enable), auto_reload,
//          count (registered), tc (one-cycle pulse), busy (RUN), done (DONE)
module downcounter_reload #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned RESET_VAL = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    downcounter_reload_if.slave   bus
);
    localparam logic [WIDTH-1:0] LP_RST_VAL = WIDTH'(RESET_VAL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= LP_RST_VAL;
            r_reload <= LP_RST_VAL;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    // Next-state and datapath; load overrides all per-state behaviour
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;

        if (bus.load) begin
            w_count_nxt  = bus.load_val;
            w_reload_nxt = bus.load_val;
            w_state_nxt  = (bus.load_val != '0) ? ST_RUN : ST_DONE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.en) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.en) begin
                        if (r_count != '0) begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end else begin
                            // Terminal edge: zero has already been visible for a cycle
                            w_tc_nxt = 1'b1;
                            if (bus.auto_reload) begin
                                w_count_nxt = r_reload;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    w_count_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.busy  = (r_state == ST_RUN);
    assign bus.done  = (r_state == ST_DONE);
endmodule
